rtc_bus_master: RTL

Parametrised transaction engine for a multiplexed address/data real-time-clock bus. It drives the ad/cs/wr/rd strobes and a shared address/data byte lane. Each request runs a complete two-phase cycle: an address phase, then a data phase that is either a write or a read. It generalises the fixed-sequence start/format/lock writer into one reusable master: higher-level control FSMs pass it address, data and direction, then wait for `done`.

---
 rtl/rtc_bus_master.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_master.sv
// rtc_bus_master: two-phase transaction engine for a multiplexed
// address/data RTC bus. Each request runs an address phase, an idle gap,
// then a write or read data phase, and ends with a one-cycle done pulse.
//
// Build option: define RTC_READ_EN to compile in the read path. Without it
// every request is a write, rd_o is tied high and rdata_o reads zero.
//
// state  | meaning
// IDLE   | waiting for start_i, strobes released, lane not driven
// A_AD   | address strobe asserted
// A_CS   | chip select asserted
// A_WR   | write strobe asserted
// A_DRV  | address driven onto the lane
// A_HOLD | address held for PULSE_CYC cycles
// A_WRH  | write strobe released
// A_CSH  | chip select released
// A_ADH  | address strobe released
// GAP    | lane driven all ones for GAP_CYC cycles
// D_CS   | chip select asserted for the data phase
// D_STB  | wr (write) or rd (read) strobe asserted
// D_DRV  | write data driven, or lane left released for a read
// D_HOLD | data held for PULSE_CYC cycles, read data sampled on exit
// D_STBH | data strobe released
// D_CSH  | chip select released
// DONE   | done pulse, outputs back at idle values

module rtc_bus_master #(
  parameter int DATA_W    = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 8
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              rnw_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ad_o,
  output logic              cs_o,
  output logic              wr_o,
  output logic              rd_o,
  output logic [DATA_W-1:0] ad_out_o,
  output logic              ad_oe_o,
  input  logic [DATA_W-1:0] ad_in_i
);

  typedef enum logic [4:0] {
    IDLE, A_AD, A_CS, A_WR, A_DRV, A_HOLD, A_WRH, A_CSH, A_ADH,
    GAP, D_CS, D_STB, D_DRV, D_HOLD, D_STBH, D_CSH, DONE
  } state_e;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              rnw_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ad_out_q;
  logic              busy_q;
  logic              done_q;
  logic              ad_q;
  logic              cs_q;
  logic              wr_q;
  logic              oe_q;
  logic              hold_last;

  assign hold_last = (cnt_q == 8'd0);

`ifdef RTC_READ_EN
  localparam logic READ_EN = 1'b1;

  logic              rd_q;
  logic [DATA_W-1:0] rdata_q;

  // Read strobe and read-data capture, slaved to the data-phase states
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_q    <= 1'b1;
      rdata_q <= '0;
    end else if (rnw_q) begin
      if (state_q == D_CS) begin
        rd_q <= 1'b0;
      end else if (state_q == D_HOLD && hold_last) begin
        rd_q    <= 1'b1;
        rdata_q <= ad_in_i;
      end
    end
  end

  assign rd_o    = rd_q;
  assign rdata_o = rdata_q;
`else
  localparam logic READ_EN = 1'b0;

  logic unused_ad_in;
  assign unused_ad_in = ^ad_in_i;

  assign rd_o    = 1'b1;
  assign rdata_o = '0;
`endif

  // Transaction sequencer; every output is set on the edge entering a state
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ad_out_q <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ad_q     <= 1'b1;
      cs_q     <= 1'b1;
      wr_q     <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rnw_q   <= rnw_i & READ_EN;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            busy_q  <= 1'b1;
            ad_q    <= 1'b0;
            // write-only builds own the lane for the whole transaction
            oe_q    <= ~READ_EN;
            state_q <= A_AD;
          end
        end
        A_AD: begin
          cs_q    <= 1'b0;
          state_q <= A_CS;
        end
        A_CS: begin
          wr_q    <= 1'b0;
          state_q <= A_WR;
        end
        A_WR: begin
          ad_out_q <= addr_q;
          oe_q     <= 1'b1;
          state_q  <= A_DRV;
        end
        A_DRV: begin
          cnt_q   <= PULSE_LOAD;
          state_q <= A_HOLD;
        end
        A_HOLD: begin
          if (hold_last) begin
            wr_q    <= 1'b1;
            state_q <= A_WRH;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        A_WRH: begin
          cs_q    <= 1'b1;
          state_q <= A_CSH;
        end
        A_CSH: begin
          ad_q    <= 1'b1;
          state_q <= A_ADH;
        end
        A_ADH: begin
          ad_out_q <= '1;
          oe_q     <= 1'b1;
          cnt_q    <= GAP_LOAD;
          state_q  <= GAP;
        end
        GAP: begin
          if (hold_last) begin
            cs_q <= 1'b0;
            // release the lane before rd can fall so the pad never fights the RTC
            if (rnw_q) oe_q <= 1'b0;
            state_q <= D_CS;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        D_CS: begin
          if (!rnw_q) wr_q <= 1'b0;
          state_q <= D_STB;
        end
        D_STB: begin
          if (!rnw_q) begin
            ad_out_q <= wdata_q;
            oe_q     <= 1'b1;
          end
          state_q <= D_DRV;
        end
        D_DRV: begin
          cnt_q   <= PULSE_LOAD;
          state_q <= D_HOLD;
        end
        D_HOLD: begin
          if (hold_last) begin
            wr_q    <= 1'b1;
            state_q <= D_STBH;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        D_STBH: begin
          cs_q    <= 1'b1;
          state_q <= D_CSH;
        end
        D_CSH: begin
          done_q   <= 1'b1;
          ad_out_q <= '1;
          oe_q     <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign ad_o     = ad_q;
  assign cs_o     = cs_q;
  assign wr_o     = wr_q;
  assign ad_out_o = ad_out_q;
  assign ad_oe_o  = oe_q;

endmodule
